i4001_bus_responder: RTL and testbench
======================================

Name: i4001_bus_responder

Overview:
Responder end of the 4004 instruction-fetch bus: a 256x8 program ROM plus a 4-bit output/input port, modelled on one i4001 chip. It follows the 8-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3) driven by the CPU via SYNC. It returns the addressed opcode nibble-wise during M1/M2 when its chip number matches, and services SRC/WRR/RDR port I/O. The ROM image is loaded through a side write port fed by the switch-entry path.

Parameters:
CHIP_ID, 4'h0, chip number compared against the A3 address nibble and the SRC chip nibble
IO_RESET, 4'h0, reset value of IO_OUT

Ports:
CLK  input  1  system clock; one bus phase per rising edge
RESET  input  1  asynchronous, active-high reset
SYNC  input  1  CPU cycle marker; high during X3, next edge starts A1
CM_ROM  input  1  CPU command line for ROM I/O (SRC at X2, I/O opcode at M2)
D_IN  input  4  resolved shared data bus value; equals D_OUT whenever D_OE=1
D_OUT  output  4  nibble driven onto the bus
D_OE  output  1  bus drive enable; top level builds the tristate
PROG_WE  input  1  program-load write strobe
PROG_ADDR  input  8  program-load address
PROG_DATA  input  8  program-load byte, [7:4]=OPR, [3:0]=OPA
IO_IN  input  4  external port inputs for RDR
IO_OUT  output  4  registered port outputs written by WRR
PHASE  output  3  current phase, 0=A1 .. 7=X3, for DMD/7-seg debug
SELECTED  output  1  SRC latch: this chip is the current I/O target

Behaviour:
- Reset (async) values: PHASE=7 (X3), addr=0, chip_hit=0, SELECTED=0, io_op=none, D_OE=0, D_OUT=0, IO_OUT=IO_RESET. Memory contents are not cleared (init 0 at configuration). After release, the next edge enters A1 even if SYNC is low.
- Phase counter: on each edge, if SYNC=1 then PHASE<=0; otherwise PHASE<=PHASE+1 mod 8.
- SYNC sampled in any phase other than X3 resynchronises: PHASE<=0, D_OE<=0, io_op cleared. SELECTED is kept.
- All actions below occur on the rising edge at which PHASE holds the named value (that edge leaves the phase):
  - A1: addr[3:0]<=D_IN.
  - A2: addr[7:4]<=D_IN.
  - A3: chip_hit<=(D_IN==CHIP_ID). If hit: D_OE<=1, D_OUT<=mem[addr][7:4]. Bus is valid throughout M1.
  - M1: if chip_hit: D_OUT<=mem[addr][3:0]. Bus is valid throughout M2.
  - M2: D_OE<=0. If CM_ROM=1 and SELECTED=1: io_op<=D_IN.
  - X1: if io_op==4'hA (RDR): D_OE<=1, D_OUT<=IO_IN sampled on this edge.
  - X2: D_OE<=0. If io_op==4'h2 (WRR): IO_OUT<=D_IN. If CM_ROM=1 (SRC): SELECTED<=(D_IN==CHIP_ID).
  - X3: io_op cleared. The X3 nibble (port/RAM address) is ignored.
- Only OPA 4'h2 (WRR) and 4'hA (RDR) act on this block. All other CM_ROM-qualified opcodes are RAM ops and are ignored.
- Fetch latency: address complete at end of A3; OPR on bus during M1, OPA during M2; bus released during X1 unless RDR.
- Non-matching chip: D_OE stays 0 for the whole cycle. It still tracks phase and SRC.
- PROG_WE: writes mem[PROG_ADDR]<=PROG_DATA on any edge, independent of phase. Reads are read-first: a write on the same edge as an A3/M1 read returns the old byte.
- No drive conflict is possible: fetch drive ends at the M2 edge, and RDR drive spans X2 only.

Test Plan:
- Load mem[0x35]=0xD7. CPU drives A1=5, A2=3, A3=CHIP_ID -> D_OE=1 with D_OUT=0xD during M1 and 0x7 during M2; D_OE=0 in X1.
- Same address but A3=CHIP_ID+1 -> D_OE=0 for all 8 phases; D_OUT is not observed.
- SRC cycle (CM_ROM=1 at X2, D_IN=CHIP_ID). Next cycle: CM_ROM=1 at M2 with OPA=0x2, D_IN=0x9 at X2 -> SELECTED=1, IO_OUT=0x9 after the X2 edge.
- SELECTED=1, IO_IN=0x6, CM_ROM=1 at M2 with OPA=0xA -> D_OE=1, D_OUT=0x6 during X2 only; WRR later with SELECTED=0 leaves IO_OUT unchanged.
- Assert SYNC at PHASE=M1 mid-drive -> next phase A1, D_OE=0. Assert RESET during M2 -> D_OE=0 immediately, PHASE=7, IO_OUT=IO_RESET.
- PROG_WE to 0x35 (0xD7->0x12) on the A3 edge -> this cycle returns D/7, the following fetch returns 1/2.

Source files
------------

// File: rtl/i4001_bus_responder.sv
// rtl/i4001_bus_responder.sv - i4001-style program ROM and 4-bit I/O port on the 4004 fetch bus
// Tracks the 8-phase machine cycle from SYNC, serves opcode nibbles in M1/M2 and handles SRC/WRR/RDR.
module i4001_bus_responder #(
  parameter logic [3:0] CHIP_ID  = 4'h0,
  parameter logic [3:0] IO_RESET = 4'h0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SYNC,
  input  logic       CM_ROM,
  input  logic [3:0] D_IN,
  output logic [3:0] D_OUT,
  output logic       D_OE,
  input  logic       PROG_WE,
  input  logic [7:0] PROG_ADDR,
  input  logic [7:0] PROG_DATA,
  input  logic [3:0] IO_IN,
  output logic [3:0] IO_OUT,
  output logic [2:0] PHASE,
  output logic       SELECTED
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_t;

  localparam logic [3:0] OP_NONE = 4'h0;
  localparam logic [3:0] OP_WRR  = 4'h2;
  localparam logic [3:0] OP_RDR  = 4'hA;

  phase_t     phase;
  logic [7:0] addr;
  logic       chip_hit;
  logic [3:0] io_op;
  logic [3:0] opa_hold;
  logic [7:0] mem [256];
  logic [7:0] rom_byte;

  assign PHASE    = phase;
  assign rom_byte = mem[addr];

  // Program store has no reset so its contents survive a CPU reset.
  always_ff @(posedge CLK) begin
    if (PROG_WE) mem[PROG_ADDR] <= PROG_DATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase    <= PH_X3;
      addr     <= 8'h00;
      chip_hit <= 1'b0;
      SELECTED <= 1'b0;
      io_op    <= OP_NONE;
      opa_hold <= 4'h0;
      D_OE     <= 1'b0;
      D_OUT    <= 4'h0;
      IO_OUT   <= IO_RESET;
    end else if (SYNC && phase != PH_X3) begin
      phase <= PH_A1;
      D_OE  <= 1'b0;
      io_op <= OP_NONE;
    end else begin
      phase <= SYNC ? PH_A1 : phase_t'(phase + 3'd1);
      case (phase)
        PH_A1: addr[3:0] <= D_IN;
        PH_A2: addr[7:4] <= D_IN;
        PH_A3: begin
          chip_hit <= (D_IN == CHIP_ID);
          // Whole byte is captured here so a later program write cannot tear the fetch.
          opa_hold <= rom_byte[3:0];
          if (D_IN == CHIP_ID) begin
            D_OE  <= 1'b1;
            D_OUT <= rom_byte[7:4];
          end
        end
        PH_M1: begin
          if (chip_hit) D_OUT <= opa_hold;
        end
        PH_M2: begin
          D_OE <= 1'b0;
          if (CM_ROM && SELECTED) io_op <= D_IN;
        end
        PH_X1: begin
          if (io_op == OP_RDR) begin
            D_OE  <= 1'b1;
            D_OUT <= IO_IN;
          end
        end
        PH_X2: begin
          D_OE <= 1'b0;
          if (io_op == OP_WRR) IO_OUT <= D_IN;
          if (CM_ROM) SELECTED <= (D_IN == CHIP_ID);
        end
        PH_X3: io_op <= OP_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_i4001_bus_responder.sv
// tb/tb_i4001_bus_responder.sv - directed scoreboard bench for i4001_bus_responder
// CPU side is modelled phase by phase; expected bus values are queued at drive time.
module tb_i4001_bus_responder;

  localparam logic [3:0] CHIP   = 4'h3;
  localparam logic [3:0] IO_RST = 4'h5;

  logic       clk = 1'b0;
  logic       reset, sync, cm_rom;
  logic [3:0] cpu_d, d_in, d_out, io_in, io_out;
  logic       d_oe, prog_we, selected;
  logic [7:0] prog_addr, prog_data;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] ph;
    logic       oe;
    logic [3:0] out;
    logic       care;
  } exp_t;
  exp_t exp_q[$];

  assign d_in = d_oe ? d_out : cpu_d;

  i4001_bus_responder #(.CHIP_ID(CHIP), .IO_RESET(IO_RST)) dut (
    .CLK(clk), .RESET(reset), .SYNC(sync), .CM_ROM(cm_rom),
    .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe),
    .PROG_WE(prog_we), .PROG_ADDR(prog_addr), .PROG_DATA(prog_data),
    .IO_IN(io_in), .IO_OUT(io_out), .PHASE(phase), .SELECTED(selected)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus phase: drive CPU side, queue expectation, compare at the falling edge.
  task automatic step(input logic [2:0] p, input logic [3:0] val, input logic cm,
                      input logic sy, input logic we, input logic eoe,
                      input logic [3:0] eout, input logic care);
    exp_t e;
    cpu_d = val; cm_rom = cm; sync = sy; prog_we = we;
    exp_q.push_back('{p, eoe, eout, care});
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("c%0d.p%0d.phase", cyc, p), 8'(phase), 8'(e.ph));
    chk($sformatf("c%0d.p%0d.d_oe", cyc, p), 8'(d_oe), 8'(e.oe));
    if (e.care) chk($sformatf("c%0d.p%0d.d_out", cyc, p), 8'(d_out), 8'(e.out));
    @(posedge clk);
    #1;
    prog_we = 1'b0; sync = 1'b0; cm_rom = 1'b0;
  endtask

  task automatic bus_cycle(input logic [7:0] a, input logic [3:0] a3, input logic [7:0] byte_exp,
                           input logic m2_cm, input logic x2_cm, input logic [3:0] x2_val,
                           input logic rdr, input logic [3:0] rdr_val,
                           input int last_ph, input logic do_sync, input int we_ph);
    logic       hit;
    logic [3:0] v;
    logic       cm, eoe, care;
    logic [3:0] eout;
    cyc++;
    hit = (a3 == CHIP);
    for (int p = 0; p <= last_ph; p++) begin
      v = 4'h0; cm = 1'b0; eoe = 1'b0; eout = 4'h0; care = 1'b0;
      case (p)
        0: v = a[3:0];
        1: v = a[7:4];
        2: v = a3;
        3: begin eoe = hit; eout = byte_exp[7:4]; care = hit; end
        4: begin eoe = hit; eout = byte_exp[3:0]; care = hit; cm = m2_cm; end
        6: begin v = x2_val; cm = x2_cm; eoe = rdr; eout = rdr_val; care = rdr; end
        7: v = 4'hF;
        default: ;
      endcase
      step(3'(p), v, cm, do_sync && (p == last_ph), (p == we_ph), eoe, eout, care);
    end
  endtask

  initial begin
    reset = 1'b1; sync = 1'b0; cm_rom = 1'b0; cpu_d = 4'h0; io_in = 4'h0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
    #1;
    chk("reset.d_oe_async", 8'(d_oe), 8'h0);
    chk("reset.phase_async", 8'(phase), 8'h7);
    prog_we = 1'b1; prog_addr = 8'h35; prog_data = 8'hD7;
    @(posedge clk); #1;
    prog_addr = 8'h40; prog_data = 8'hE2;
    @(posedge clk); #1;
    prog_addr = 8'h41; prog_data = 8'hEA;
    @(posedge clk); #1;
    prog_we = 1'b0;
    @(negedge clk);
    chk("reset.phase", 8'(phase), 8'h7);
    chk("reset.d_oe", 8'(d_oe), 8'h0);
    chk("reset.d_out", 8'(d_out), 8'h0);
    chk("reset.io_out", 8'(io_out), 8'(IO_RST));
    chk("reset.selected", 8'(selected), 8'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Matching fetch, then a non-matching chip on the same address.
    bus_cycle(8'h35, CHIP, 8'hD7, 0, 0, 4'h0, 0, 4'h0, 7, 1, 8);
    bus_cycle(8'h35, CHIP + 4'h1, 8'hD7, 0, 0, 4'h0, 0, 4'h0, 7, 1, 8);

    // SRC selects this chip, then WRR from ROM writes the port.
    bus_cycle(8'h35, CHIP + 4'h1, 8'hD7, 0, 1, CHIP, 0, 4'h0, 7, 1, 8);
    chk("src.selected", 8'(selected), 8'h1);
    bus_cycle(8'h40, CHIP, 8'hE2, 1, 0, 4'h9, 0, 4'h0, 7, 1, 8);
    chk("wrr.io_out", 8'(io_out), 8'h9);

    io_in = 4'h6;
    bus_cycle(8'h41, CHIP, 8'hEA, 1, 0, 4'h0, 1, 4'h6, 7, 1, 8);
    chk("rdr.io_out_kept", 8'(io_out), 8'h9);

    // Deselect, then WRR must not touch the port.
    bus_cycle(8'h35, CHIP + 4'h1, 8'hD7, 0, 1, 4'h5, 0, 4'h0, 7, 1, 8);
    chk("src.deselect", 8'(selected), 8'h0);
    bus_cycle(8'h40, CHIP, 8'hE2, 1, 0, 4'hC, 0, 4'h0, 7, 1, 8);
    chk("wrr_unsel.io_out", 8'(io_out), 8'h9);

    // SYNC during M1 aborts the drive; next cycle's A1 step checks phase 0 and D_OE 0.
    bus_cycle(8'h35, CHIP, 8'hD7, 0, 0, 4'h0, 0, 4'h0, 3, 1, 8);

    // Program write on the A3 edge: this fetch sees the old byte, the next the new one.
    prog_addr = 8'h35; prog_data = 8'h12;
    bus_cycle(8'h35, CHIP, 8'hD7, 0, 0, 4'h0, 0, 4'h0, 7, 1, 2);
    bus_cycle(8'h35, CHIP, 8'h12, 0, 0, 4'h0, 0, 4'h0, 7, 1, 8);

    // Reset asserted mid-drive in M2.
    bus_cycle(8'h35, CHIP, 8'h12, 0, 0, 4'h0, 0, 4'h0, 3, 0, 8);
    chk("pre_reset.phase", 8'(phase), 8'h4);
    chk("pre_reset.d_oe", 8'(d_oe), 8'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset.d_oe", 8'(d_oe), 8'h0);
    chk("mid_reset.phase", 8'(phase), 8'h7);
    chk("mid_reset.io_out", 8'(io_out), 8'(IO_RST));
    @(posedge clk); #1;
    reset = 1'b0;
    chk("scoreboard.empty", 8'(exp_q.size()), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
